// File: rtl/lsu_gpio_pkg.sv
// Shared types and constants for the LSU AXI GPIO write slave.
package lsu_gpio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_W,
    ST_WAIT_AW,
    ST_DRAIN,
    ST_RESP
  } gpio_state_t;

  localparam logic [1:0] OFS_OUT = 2'd0;
  localparam logic [1:0] OFS_OE  = 2'd1;
  localparam logic [1:0] OFS_SET = 2'd2;
  localparam logic [1:0] OFS_CLR = 2'd3;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_beat_t;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/lsu_gpio_regs.sv
// GPIO OUT/OE register bank with byte-strobe merge and SET/CLR aliases.
module lsu_gpio_regs
  import lsu_gpio_pkg::*;
#(
  parameter int unsigned IO_W = 28
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            we,
  input  logic [1:0]      idx,
  input  logic [31:0]     data,
  input  logic [3:0]      strb,
  output logic [IO_W-1:0] gpio_out,
  output logic [IO_W-1:0] gpio_oe
);

  logic [31:0] mask_c;
  logic [31:0] dm_c;
  logic [31:0] out_cur_c;
  logic [31:0] oe_cur_c;
  logic [31:0] out_nxt_c;
  logic [31:0] oe_nxt_c;

  // Next register values; bits at or above IO_W fall away on truncation.
  always_comb begin
    mask_c    = byte_mask(strb);
    dm_c      = data & mask_c;
    out_cur_c = 32'(gpio_out);
    oe_cur_c  = 32'(gpio_oe);
    out_nxt_c = out_cur_c;
    oe_nxt_c  = oe_cur_c;
    case (idx)
      OFS_OUT: out_nxt_c = (out_cur_c & ~mask_c) | dm_c;
      OFS_OE:  oe_nxt_c  = (oe_cur_c & ~mask_c) | dm_c;
      OFS_SET: out_nxt_c = out_cur_c | dm_c;
      OFS_CLR: out_nxt_c = out_cur_c & ~dm_c;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
    end else if (we) begin
      gpio_out <= IO_W'(out_nxt_c);
      gpio_oe  <= IO_W'(oe_nxt_c);
    end
  end

endmodule

// File: rtl/lsu_axi_gpio_wr_slave.sv
// AXI4 write responder for the LSU GPIO register window.
// Define LSU_GPIO_DECERR_EN to answer window misses with DECERR instead of OKAY.
module lsu_axi_gpio_wr_slave
  import lsu_gpio_pkg::*;
#(
  parameter int unsigned      ID_W      = 3,
  parameter int unsigned      ADDR_W    = 32,
  parameter int unsigned      IO_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'hD000_0000)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              lsu_axi_awvalid,
  output logic              lsu_axi_awready,
  input  logic [ID_W-1:0]   lsu_axi_awid,
  input  logic [ADDR_W-1:0] lsu_axi_awaddr,
  input  logic [7:0]        lsu_axi_awlen,
  input  logic              lsu_axi_wvalid,
  output logic              lsu_axi_wready,
  input  logic [63:0]       lsu_axi_wdata,
  input  logic [7:0]        lsu_axi_wstrb,
  input  logic              lsu_axi_wlast,
  output logic              lsu_axi_bvalid,
  input  logic              lsu_axi_bready,
  output logic [1:0]        lsu_axi_bresp,
  output logic [ID_W-1:0]   lsu_axi_bid,
  output logic [IO_W-1:0]   gpio_out,
  output logic [IO_W-1:0]   gpio_oe,
  output logic              wr_pulse
);

  gpio_state_t       state;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_len;
  logic [ID_W-1:0]   cap_id;
  w_beat_t           cap_w;

  w_beat_t           w_live_c;
  logic              fire_c;
  logic [ADDR_W-1:0] f_addr;
  logic [7:0]        f_len;
  logic [ID_W-1:0]   f_id;
  w_beat_t           f_w;
  logic              burst_c;
  logic              to_drain_c;
  logic              hit_c;
  logic [31:0]       lane_data_c;
  logic [3:0]        lane_strb_c;
  logic              we_c;
  logic [1:0]        resp_c;
  logic              unused_addr_bits;

  assign w_live_c = '{data: lsu_axi_wdata, strb: lsu_axi_wstrb, last: lsu_axi_wlast};

  // Pick the AW/W halves (live or captured) completing a transaction this cycle.
  always_comb begin
    fire_c = 1'b0;
    f_addr = cap_addr;
    f_len  = cap_len;
    f_id   = cap_id;
    f_w    = cap_w;
    case (state)
      ST_IDLE: if (lsu_axi_awvalid && lsu_axi_wvalid) begin
        fire_c = 1'b1;
        f_addr = lsu_axi_awaddr;
        f_len  = lsu_axi_awlen;
        f_id   = lsu_axi_awid;
        f_w    = w_live_c;
      end
      ST_WAIT_W: if (lsu_axi_wvalid) begin
        fire_c = 1'b1;
        f_w    = w_live_c;
      end
      ST_WAIT_AW: if (lsu_axi_awvalid) begin
        fire_c = 1'b1;
        f_addr = lsu_axi_awaddr;
        f_len  = lsu_axi_awlen;
        f_id   = lsu_axi_awid;
      end
      default: ;
    endcase
  end

  assign burst_c     = (f_len != 8'd0);
  assign to_drain_c  = burst_c && !f_w.last;
  assign hit_c       = (f_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign lane_data_c = f_addr[2] ? f_w.data[63:32] : f_w.data[31:0];
  assign lane_strb_c = f_addr[2] ? f_w.strb[7:4]   : f_w.strb[3:0];
  assign we_c        = fire_c && !to_drain_c && hit_c && !burst_c;
  assign unused_addr_bits = ^f_addr[1:0];

  // Burst error outranks the decode result.
  always_comb begin
    resp_c = BRESP_OKAY;
    if (burst_c) begin
      resp_c = BRESP_SLVERR;
    end else if (!hit_c) begin
`ifdef LSU_GPIO_DECERR_EN
      resp_c = BRESP_DECERR;
`else
      resp_c = BRESP_OKAY;
`endif
    end
  end

  lsu_gpio_regs #(
    .IO_W (IO_W)
  ) u_regs (
    .clk      (clk),
    .rst_l    (rst_l),
    .we       (we_c),
    .idx      (f_addr[3:2]),
    .data     (lane_data_c),
    .strb     (lane_strb_c),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe)
  );

  // Handshake FSM; ready/valid outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= ST_IDLE;
      lsu_axi_awready <= 1'b1;
      lsu_axi_wready  <= 1'b1;
      lsu_axi_bvalid  <= 1'b0;
      lsu_axi_bresp   <= BRESP_OKAY;
      lsu_axi_bid     <= '0;
      wr_pulse        <= 1'b0;
      cap_addr        <= '0;
      cap_len         <= '0;
      cap_id          <= '0;
      cap_w           <= '0;
    end else begin
      wr_pulse <= we_c && (lane_strb_c != 4'd0);

      if (lsu_axi_awvalid && lsu_axi_awready) begin
        cap_addr <= lsu_axi_awaddr;
        cap_len  <= lsu_axi_awlen;
        cap_id   <= lsu_axi_awid;
      end
      if (lsu_axi_wvalid && lsu_axi_wready && (state != ST_DRAIN)) begin
        cap_w <= w_live_c;
      end

      case (state)
        ST_IDLE: begin
          if (lsu_axi_awvalid && !lsu_axi_wvalid) begin
            state           <= ST_WAIT_W;
            lsu_axi_awready <= 1'b0;
          end else if (!lsu_axi_awvalid && lsu_axi_wvalid) begin
            state          <= ST_WAIT_AW;
            lsu_axi_wready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (lsu_axi_wvalid && lsu_axi_wlast) begin
            state          <= ST_RESP;
            lsu_axi_wready <= 1'b0;
            lsu_axi_bvalid <= 1'b1;
            lsu_axi_bid    <= cap_id;
            lsu_axi_bresp  <= BRESP_SLVERR;
          end
        end
        ST_RESP: begin
          if (lsu_axi_bready) begin
            state           <= ST_IDLE;
            lsu_axi_bvalid  <= 1'b0;
            lsu_axi_awready <= 1'b1;
            lsu_axi_wready  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (fire_c) begin
        lsu_axi_awready <= 1'b0;
        if (to_drain_c) begin
          state          <= ST_DRAIN;
          lsu_axi_wready <= 1'b1;
        end else begin
          state          <= ST_RESP;
          lsu_axi_wready <= 1'b0;
          lsu_axi_bvalid <= 1'b1;
          lsu_axi_bid    <= f_id;
          lsu_axi_bresp  <= resp_c;
        end
      end
    end
  end

endmodule
